// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: refill FSM states, line geometry and a line-align helper.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_IDX_W      = $clog2(ICACHE_LINE_WORDS);
    localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_WORDS * ICACHE_DATA_W / 8);

    // Clear the byte-offset bits so the address points at the first word of its line.
    function automatic logic [ICACHE_ADDR_W-1:0] line_align(input logic [ICACHE_ADDR_W-1:0] addr);
        return addr & {{(ICACHE_ADDR_W-ICACHE_OFF_W){1'b1}}, {ICACHE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Counts response beats within a line refill; wraps naturally at LINE_WORDS (power of 2).
module refill_beat_counter
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clr,
    input  logic                          inc,
    output logic [$clog2(LINE_WORDS)-1:0] cnt,
    output logic                          last
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (inc) cnt_d = cnt_q + 1'b1;
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill controller: detects a fetch miss, reads one line from memory beat by beat,
// writes it into the data array, then writes tag/valid and releases the front-end stall.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          LookupF,
    input  logic                          HitF,
    input  logic [ADDR_W-1:0]             PCF,
    output logic                          InstrMissF,
    output logic                          InstrCacheRepActive,
    output logic                          MemReqValid,
    input  logic                          MemReqReady,
    output logic [ADDR_W-1:0]             MemReqAddr,
    input  logic                          MemRespValid,
    input  logic [DATA_W-1:0]             MemRespData,
    output logic                          LineWrEn,
    output logic [$clog2(LINE_WORDS)-1:0] LineWrIdx,
    output logic [DATA_W-1:0]             LineWrData,
    output logic                          TagWrEn,
    output logic [ADDR_W-1:0]             RefillAddr
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    refill_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  beat_cnt;
    logic              beat_last;
    logic              miss_lookup;

    assign miss_lookup = LookupF & ~HitF;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Address is captured only when leaving IDLE; redirects during a refill cannot move it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: if (miss_lookup) begin
                state_d = REQ;
                addr_d  = PCF & LINE_MASK;
            end
            REQ:  if (MemReqReady) state_d = FILL;
            FILL: if (MemRespValid && beat_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        InstrMissF          = 1'b0;
        InstrCacheRepActive = 1'b0;
        MemReqValid         = 1'b0;
        LineWrEn            = 1'b0;
        TagWrEn             = 1'b0;
        unique case (state_q)
            IDLE: InstrMissF = miss_lookup & reset_n;
            REQ: begin
                InstrMissF          = 1'b1;
                InstrCacheRepActive = 1'b1;
                MemReqValid         = 1'b1;
            end
            FILL: begin
                InstrMissF          = 1'b1;
                InstrCacheRepActive = 1'b1;
                LineWrEn            = MemRespValid;
            end
            DONE: begin
                InstrMissF          = 1'b1;
                InstrCacheRepActive = 1'b1;
                TagWrEn             = 1'b1;
            end
            default: ;
        endcase
    end

    refill_beat_counter #(.LINE_WORDS(LINE_WORDS)) u_beat_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state_q == REQ) && MemReqReady),
        .inc     ((state_q == FILL) && MemRespValid),
        .cnt     (beat_cnt),
        .last    (beat_last)
    );

    assign MemReqAddr = addr_q;
    assign RefillAddr = addr_q;
    assign LineWrIdx  = beat_cnt;
    assign LineWrData = LineWrEn ? MemRespData : '0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: expected memory/array events go into a scoreboard queue
// and a negedge monitor pops and compares each event the DUT produces.
module tb_icache_refill_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINE_WORDS = 4;

    localparam int EV_REQ = 0;
    localparam int EV_WR  = 1;
    localparam int EV_TAG = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              LookupF, HitF;
    logic [ADDR_W-1:0] PCF;
    logic              InstrMissF, InstrCacheRepActive;
    logic              MemReqValid, MemReqReady;
    logic [ADDR_W-1:0] MemReqAddr;
    logic              MemRespValid;
    logic [DATA_W-1:0] MemRespData;
    logic              LineWrEn;
    logic [1:0]        LineWrIdx;
    logic [DATA_W-1:0] LineWrData;
    logic              TagWrEn;
    logic [ADDR_W-1:0] RefillAddr;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  miss_cnt = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .LookupF             (LookupF),
        .HitF                (HitF),
        .PCF                 (PCF),
        .InstrMissF          (InstrMissF),
        .InstrCacheRepActive (InstrCacheRepActive),
        .MemReqValid         (MemReqValid),
        .MemReqReady         (MemReqReady),
        .MemReqAddr          (MemReqAddr),
        .MemRespValid        (MemRespValid),
        .MemRespData         (MemRespData),
        .LineWrEn            (LineWrEn),
        .LineWrIdx           (LineWrIdx),
        .LineWrData          (LineWrData),
        .TagWrEn             (TagWrEn),
        .RefillAddr          (RefillAddr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic mon(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d a=%h d=%h, expected none", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.d !== d) begin
                n_bad++;
                $display("FAIL event: got kind=%0d a=%h d=%h, expected kind=%0d a=%h d=%h",
                         k, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (InstrMissF) miss_cnt++;
        if (reset_n) begin
            if (MemReqValid && MemReqReady) mon(EV_REQ, MemReqAddr, 32'h0);
            if (LineWrEn)                   mon(EV_WR, 32'(LineWrIdx), LineWrData);
            if (TagWrEn)                    mon(EV_TAG, RefillAddr, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_flags"}, 32'({InstrMissF, InstrCacheRepActive, MemReqValid, LineWrEn, TagWrEn}), 32'h0);
        chk({nm, "_buses"}, MemReqAddr | RefillAddr | LineWrData | 32'(LineWrIdx), 32'h0);
    endtask

    // One complete refill; a spurious beat is driven in the REQ handshake cycle and in DONE.
    task automatic refill(input logic [31:0] pc, input logic [31:0] base,
                          input int rdy_dly, input int gap, input bit redirect);
        logic [31:0] line;
        line = pc & 32'hFFFF_FFF0;
        push(EV_REQ, line, 32'h0);
        for (int i = 0; i < LINE_WORDS; i++) push(EV_WR, 32'(i), base + 32'(i));
        push(EV_TAG, line, 32'h0);

        LookupF = 1'b1; HitF = 1'b0; PCF = pc;
        #1 chk("miss_in_idle", 32'(InstrMissF), 32'h1);
        chk("idle_not_active", 32'(InstrCacheRepActive), 32'h0);
        tick();
        LookupF = 1'b0;
        for (int d = 0; d < rdy_dly; d++) begin
            MemReqReady = 1'b0;
            #1 chk("req_valid_held", 32'(MemReqValid), 32'h1);
            chk("req_addr_held", MemReqAddr, line);
            tick();
        end
        MemReqReady = 1'b1; MemRespValid = 1'b1; MemRespData = 32'hBAD0;
        #1 chk("req_valid", 32'(MemReqValid), 32'h1);
        tick();
        MemReqReady = 1'b0; MemRespValid = 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            MemRespValid = 1'b1; MemRespData = base + 32'(i);
            tick();
            MemRespValid = 1'b0;
            if (redirect && i == 1) begin
                PCF = 32'h2000; LookupF = 1'b1; HitF = 1'b0;
            end
            if (i < LINE_WORDS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    #1 chk("gap_active", 32'(InstrCacheRepActive), 32'h1);
                    tick();
                end
            end
        end
        MemRespValid = 1'b1; MemRespData = 32'hDEAD;
        #1 chk("done_tagwr", 32'(TagWrEn), 32'h1);
        tick();
        MemRespValid = 1'b0;
        #1 chk("idle_after_done", 32'(InstrCacheRepActive), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int m0;
        reset_n = 1'b0; LookupF = 1'b0; HitF = 1'b0; PCF = '0;
        MemReqReady = 1'b0; MemRespValid = 1'b0; MemRespData = '0;
        #2 chk_zero("reset");
        tick(); tick();
        reset_n = 1'b1;

        // hits never request memory
        LookupF = 1'b1; HitF = 1'b1; PCF = 32'h100;
        for (int i = 0; i < 10; i++) begin
            #1 chk("hit_no_miss", 32'(InstrMissF), 32'h0);
            chk("hit_no_req", 32'(MemReqValid), 32'h0);
            tick();
        end

        // no lookup: no miss regardless of HitF; spurious beats in IDLE must not write
        LookupF = 1'b0; HitF = 1'b0; MemRespValid = 1'b1; MemRespData = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            #1 chk("nolookup_no_miss", 32'(InstrMissF), 32'h0);
            tick();
        end
        MemRespValid = 1'b0;

        // clean miss: stall lasts miss + REQ + 4 FILL + DONE
        m0 = miss_cnt;
        refill(32'h1234, 32'hA0, 0, 0, 1'b0);
        tick();
        chk("miss_cycles", 32'(miss_cnt - m0), 32'd7);

        // request backpressure and gaps between beats
        refill(32'h1234, 32'hB0, 3, 2, 1'b0);

        // redirect after beat 1, then the new PC misses and refills its own line
        refill(32'h1234, 32'hC0, 0, 0, 1'b1);
        refill(32'h2000, 32'hD0, 0, 0, 1'b0);

        // reset after beat 2; the remaining beats are dropped
        push(EV_REQ, 32'h3340, 32'h0);
        for (int i = 0; i < 3; i++) push(EV_WR, 32'(i), 32'hE0 + 32'(i));
        LookupF = 1'b1; HitF = 1'b0; PCF = 32'h3344;
        tick();
        LookupF = 1'b0; MemReqReady = 1'b1;
        tick();
        MemReqReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemRespValid = 1'b1; MemRespData = 32'hE0 + 32'(i);
            tick();
        end
        reset_n = 1'b0; MemRespData = 32'hE3;
        #1 chk_zero("reset_mid_fill");
        tick(); tick();
        reset_n = 1'b1; MemRespData = 32'hE4;
        tick(); tick();
        MemRespValid = 1'b0;
        #1 chk("idle_after_reset", 32'(InstrCacheRepActive), 32'h0);
        refill(32'h5678, 32'hF0, 1, 1, 1'b0);

        tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
